ordenador_driver: RTL

Host-side sequencer for the 9-entry, 8-bit sorting engine. It accepts a frame of 9 bytes on a valid/ready input stream, writes them into the engine's input memory, pulses `srt_start`, and waits for `srt_idle` to drop and then return. It then reads the 9 sorted results back through the engine's read port and emits them on a valid/ready output stream. It sits between the streaming datapath and the sorter, and is the only agent that drives the sorter's write, start and read ports.

---
 rtl/ordenador_pkg.sv | 20 ++
 rtl/ordenador_wdog.sv | 38 +++
 rtl/ordenador_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ordenador_pkg.sv
// Shared definitions for the sorting-engine host driver.
//   drv_state_t : driver FSM states
//   ORD_N       : elements per frame (engine memory depth)
//   ORD_W       : element width
//   ORD_AW      : engine address width
package ordenador_pkg;

  localparam int ORD_N  = 9;
  localparam int ORD_W  = 8;
  localparam int ORD_AW = 4;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_KICK      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_READ      = 3'd4
  } drv_state_t;

endpackage

// File: rtl/ordenador_wdog.sv
// Watchdog for the sort-wait phase.
//   clock, reset : clock, async active-high reset
//   clr          : zero the count
//   en           : count this cycle
//   expired      : this enabled cycle brings the count up to TIMEOUT
module ordenador_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating so a stuck enable can never wrap back below TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CW'(TIMEOUT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The current cycle is counted too, so at most TIMEOUT cycles are spent
  // waiting before the frame is abandoned.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ordenador_driver.sv
// Host-side sequencer for the 9-entry sorting engine.
// Loads a 9-byte frame from the input stream into the engine, starts it,
// waits for completion (with watchdog) and streams the sorted results out.
//   clock, reset                   : clock, async active-high reset
//   s_valid/s_ready/s_data         : input byte stream
//   m_valid/m_ready/m_data/m_last  : sorted output stream
//   srt_wa/srt_din                 : engine write port (registered)
//   srt_start                      : one-cycle engine start
//   srt_ra/srt_dout                : engine read port (dout is combinational)
//   srt_idle                       : engine idle / write port live
//   busy                           : high outside LOAD
//   err_timeout                    : sticky watchdog error
module ordenador_driver
  import ordenador_pkg::*;
#(
  parameter int N          = ORD_N,
  parameter int W          = ORD_W,
  parameter int TIMEOUT    = 15,
  parameter bit DESCENDING = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_data,
  output logic              m_last,
  output logic [ORD_AW-1:0] srt_wa,
  output logic [W-1:0]      srt_din,
  output logic              srt_start,
  output logic [ORD_AW-1:0] srt_ra,
  input  logic [W-1:0]      srt_dout,
  input  logic              srt_idle,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [ORD_AW-1:0] LAST = ORD_AW'(N - 1);

  drv_state_t        state_q, state_d;
  logic [ORD_AW-1:0] idx_q, idx_d;
  logic [ORD_AW-1:0] wa_q, wa_d;
  logic [W-1:0]      din_q, din_d;
  logic              err_q, err_d;
  logic              wd_clr, wd_en, wd_expired;
  logic              s_fire, m_fire;

  ordenador_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Gated by reset so the stream sees no ready while held in reset.
  assign s_ready = (state_q == ST_LOAD) && !reset;
  assign m_valid = (state_q == ST_READ);
  assign m_last  = (state_q == ST_READ) && (idx_q == LAST);
  assign m_data  = (state_q == ST_READ) ? srt_dout : '0;
  assign srt_start   = (state_q == ST_KICK);
  assign busy        = (state_q != ST_LOAD);
  assign srt_wa      = wa_q;
  assign srt_din     = din_q;
  assign err_timeout = err_q;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // Engine address 0 holds the minimum; descending order walks it backwards.
  always_comb begin
    srt_ra = '0;
    if (state_q == ST_READ)
      srt_ra = DESCENDING ? (LAST - idx_q) : idx_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wa_d    = wa_q;
    din_d   = din_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (s_fire) begin
          wa_d  = idx_q;
          din_d = s_data;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = ST_KICK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      // Write port still shows the last element, so the engine takes it
      // on the same edge it sees start.
      ST_KICK: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else if (!srt_idle) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = ST_LOAD;
        end else if (srt_idle) begin
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (m_fire) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      wa_q    <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wa_q    <= wa_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

endmodule
